// File: rtl/mod_addsub_ctrl_pkg.sv
// Shared definitions for the modular add/subtract sequencer and other mpadder
// users: default operand width, FSM state encoding and adder mode encoding.
package mod_addsub_ctrl_pkg;

   // Default operand/modulus width; the adder result is one bit wider.
   localparam int MAS_WIDTH = 1027;

   // FSM state encoding.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ1  = 3'd1;
   localparam logic [2:0] ST_WAIT1 = 3'd2;
   localparam logic [2:0] ST_REQ2  = 3'd3;
   localparam logic [2:0] ST_WAIT2 = 3'd4;
   localparam logic [2:0] ST_FIN   = 3'd5;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      REQ1  = ST_REQ1,
      WAIT1 = ST_WAIT1,
      REQ2  = ST_REQ2,
      WAIT2 = ST_WAIT2,
      FIN   = ST_FIN
   } state_t;

   // mpadder mode encoding.
   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer: computes (a+b) mod m or (a-b) mod m for
// operands below m using exactly two operations on a shared mpadder, so the
// request timing does not depend on the data. The reduced result is picked
// locally from the carry/borrow bits of the two adder results.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   start, subtract        request pulse (sampled in IDLE) and mode
//   in_a, in_b, in_m       operands (< m) and odd modulus, sampled with start
//   result, done, busy     registered result, one-cycle done pulse, busy flag
//   add_start, add_subtract, add_in_a, add_in_b   requests to the mpadder
//   add_result, add_done   mpadder response (WIDTH+1 bit result)
module mod_addsub_ctrl
   import mod_addsub_ctrl_pkg::*;
#(
   parameter int WIDTH = MAS_WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             subtract,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy,
   output logic             add_start,
   output logic             add_subtract,
   output logic [WIDTH-1:0] add_in_a,
   output logic [WIDTH-1:0] add_in_b,
   input  logic [WIDTH:0]   add_result,
   input  logic             add_done
);

   state_t           state_reg, state_next;
   logic             mode_reg;
   logic [WIDTH-1:0] m_reg;
   logic [WIDTH-1:0] op_a_reg, op_b_reg;
   logic             op_sub_reg;
   logic [WIDTH:0]   s_reg, t_reg;
   logic [WIDTH-1:0] result_reg;
   logic             done_reg;
   logic [WIDTH-1:0] sel_next;

   // Next-state logic and adder request strobe.
   always_comb begin
      state_next = state_reg;
      add_start  = 1'b0;
      case (state_reg)
         // A start coinciding with the done pulse is not accepted; the next
         // request is taken from the cycle after done.
         IDLE:    if (start && !done_reg) state_next = REQ1;
         REQ1: begin
            add_start  = 1'b1;
            state_next = WAIT1;
         end
         WAIT1:   if (add_done) state_next = REQ2;
         REQ2: begin
            add_start  = 1'b1;
            state_next = WAIT2;
         end
         WAIT2:   if (add_done) state_next = FIN;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Final reduction select.
   //   add: s = a+b, t = s-m. Take t if s overflowed WIDTH bits (then s > m
   //        for sure) or if s-m did not borrow.
   //   sub: s = a-b, t = s+m. Take s if a-b did not borrow; t's carry is the
   //        expected wrap of the modular correction and is ignored.
   always_comb begin
      sel_next = s_reg[WIDTH-1:0];
      if (mode_reg == MODE_SUB) begin
         if (!s_reg[WIDTH]) sel_next = t_reg[WIDTH-1:0];
      end else begin
         if (s_reg[WIDTH] || t_reg[WIDTH]) sel_next = t_reg[WIDTH-1:0];
      end
   end

   // State and datapath registers. The adder operand registers double as the
   // latched a/b of the request and change only when entering REQ1/REQ2.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg  <= IDLE;
         mode_reg   <= MODE_ADD;
         m_reg      <= '0;
         op_a_reg   <= '0;
         op_b_reg   <= '0;
         op_sub_reg <= 1'b0;
         s_reg      <= '0;
         t_reg      <= '0;
         result_reg <= '0;
         done_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start && !done_reg) begin
                  mode_reg   <= subtract ? MODE_SUB : MODE_ADD;
                  m_reg      <= in_m;
                  op_a_reg   <= in_a;
                  op_b_reg   <= in_b;
                  op_sub_reg <= subtract;
               end
            end
            WAIT1: begin
               if (add_done) begin
                  s_reg      <= add_result;
                  op_a_reg   <= add_result[WIDTH-1:0];
                  op_b_reg   <= m_reg;
                  // Correction step runs in the opposite direction.
                  op_sub_reg <= (mode_reg == MODE_ADD);
               end
            end
            WAIT2: begin
               if (add_done) t_reg <= add_result;
            end
            FIN: begin
               result_reg <= sel_next;
               done_reg   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign result       = result_reg;
   assign done         = done_reg;
   // Busy spans the whole operation up to and including the done cycle.
   assign busy         = (state_reg != IDLE) || done_reg;
   assign add_subtract = op_sub_reg;
   assign add_in_a     = op_a_reg;
   assign add_in_b     = op_b_reg;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Testbench for mod_addsub_ctrl: a behavioural mpadder with programmable
// latency answers the adder requests; results are compared with a modular
// arithmetic reference model.
module tb_mod_addsub_ctrl;
   import mod_addsub_ctrl_pkg::*;

   localparam int W = MAS_WIDTH;
   localparam int TMO = 400;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         start = 1'b0;
   logic         subtract = 1'b0;
   logic [W-1:0] in_a = '0, in_b = '0, in_m = '0;
   logic [W-1:0] result, add_in_a, add_in_b;
   logic         done, busy, add_start, add_subtract;
   logic         add_done = 1'b0;
   logic [W:0]   add_result = '0;

   int checks = 0;
   int failures = 0;
   int lat = 2;
   int pend = 0;
   logic [W:0] pres = '0;
   int starts_seen = 0, dones_seen = 0, overlaps = 0, txn = 0;

   mod_addsub_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
      .in_a(in_a), .in_b(in_b), .in_m(in_m),
      .result(result), .done(done), .busy(busy),
      .add_start(add_start), .add_subtract(add_subtract),
      .add_in_a(add_in_a), .add_in_b(add_in_b),
      .add_result(add_result), .add_done(add_done)
   );

   always #5 clk = ~clk;

   // mpadder behaviour: add gives the true WIDTH+1 bit sum; subtract gives
   // bit WIDTH = 1 when there is no borrow.
   function automatic logic [W:0] adder_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sub);
      if (sub) return {1'b1, a} - {1'b0, b};
      return {1'b0, a} + {1'b0, b};
   endfunction

   // Reference: plain modular arithmetic.
   function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m, input logic sub);
      logic [W+1:0] x, r;
      if (sub) x = {2'b00, a} + {2'b00, m} - {2'b00, b};
      else     x = {2'b00, a} + {2'b00, b};
      r = x % {2'b00, m};
      return r[W-1:0];
   endfunction

   function automatic logic [W-1:0] rand_wide();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < 33; i++) v = {v[W-33:0], 32'($urandom())};
      return v;
   endfunction

   // Responder with latency lat (add_start cycle to add_done cycle).
   always @(posedge clk) begin
      add_done <= 1'b0;
      if (pend > 0) begin
         pend <= pend - 1;
         if (pend == 1) begin
            add_done   <= 1'b1;
            add_result <= pres;
         end
      end
      if (add_start) begin
         if (pend != 0) overlaps++;
         if (lat <= 1) begin
            add_done   <= 1'b1;
            add_result <= adder_model(add_in_a, add_in_b, add_subtract);
            pend       <= 0;
         end else begin
            pres <= adder_model(add_in_a, add_in_b, add_subtract);
            pend <= lat - 1;
         end
      end
   end

   always @(posedge clk) begin
      if (add_start) starts_seen++;
      if (done) dones_seen++;
   end

   // Drives one request and measures it. With b2b=1 start is raised in the
   // current cycle instead of after the next edge. poke_at raises a stray
   // start in that cycle of the operation. Inputs are scrambled after start.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                         input logic sub, input int l, input int poke_at, input bit b2b,
                         output logic [W-1:0] res, output int n, output int d_done,
                         output int d_start, output logic after_done, output logic after_busy,
                         output bit busy_gap);
      int s0, d0;
      lat = l;
      if (!b2b) begin
         @(posedge clk);
         #1;
      end
      s0 = starts_seen;
      d0 = dones_seen;
      in_a = a; in_b = b; in_m = m; subtract = sub; start = 1'b1;
      n = 0;
      busy_gap = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         start = (n == poke_at);
         subtract = 1'($urandom());
         in_a = rand_wide(); in_b = rand_wide(); in_m = rand_wide();
         if (!busy) busy_gap = 1;
      end while (!done && n < TMO);
      res = result;
      @(posedge clk);
      #1;
      start = 1'b0;
      d_done = dones_seen - d0;
      d_start = starts_seen - s0;
      after_done = done;
      after_busy = busy;
      txn++;
      $display("txn %0d mode=%0d L=%0d cycles=%0d a_lo=%h b_lo=%h m_lo=%h res_lo=%h",
               txn, sub, l, n, a[31:0], b[31:0], m[31:0], res[31:0]);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h want=0", result[31:0]); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (add_start !== 1'b0) begin failures++; $display("FAIL reset_add_start got=%b want=0", add_start); end
      checks++; if (add_subtract !== 1'b0) begin failures++; $display("FAIL reset_add_subtract got=%b want=0", add_subtract); end
      checks++; if (add_in_a !== '0) begin failures++; $display("FAIL reset_add_in_a got=%h want=0", add_in_a[31:0]); end
      checks++; if (add_in_b !== '0) begin failures++; $display("FAIL reset_add_in_b got=%h want=0", add_in_b[31:0]); end
      resetn = 1'b1;
   endtask

   task automatic test_directed();
      logic [W-1:0] da[5], db[5], dm[5], dexp[5], res;
      logic         dsub[5];
      logic         ad, ab;
      bit           bg;
      int           n, dd, ds;
      da[0] = W'(5);  db[0] = W'(6); dm[0] = W'(13); dsub[0] = 1'b0; dexp[0] = W'(11);
      da[1] = W'(7);  db[1] = W'(9); dm[1] = W'(13); dsub[1] = 1'b0; dexp[1] = W'(3);
      da[2] = W'(3);  db[2] = W'(8); dm[2] = W'(13); dsub[2] = 1'b1; dexp[2] = W'(8);
      da[3] = W'(8);  db[3] = W'(3); dm[3] = W'(13); dsub[3] = 1'b1; dexp[3] = W'(5);
      dm[4] = '1; da[4] = dm[4] - W'(1); db[4] = da[4]; dsub[4] = 1'b0; dexp[4] = dm[4] - W'(2);
      for (int i = 0; i < 5; i++) begin
         run_op(da[i], db[i], dm[i], dsub[i], 3, 0, 1'b0, res, n, dd, ds, ad, ab, bg);
         checks++; if (res !== dexp[i]) begin failures++; $display("FAIL dir%0d_result got=%h want=%h", i, res[31:0], dexp[i][31:0]); end
         checks++; if (n !== 10) begin failures++; $display("FAIL dir%0d_latency got=%0d want=10", i, n); end
         checks++; if (ds !== 2) begin failures++; $display("FAIL dir%0d_add_starts got=%0d want=2", i, ds); end
         checks++; if (dd !== 1 || ad !== 1'b0) begin failures++; $display("FAIL dir%0d_done_pulse got=%0d/%b want=1/0", i, dd, ad); end
         checks++; if (bg || ab !== 1'b0) begin failures++; $display("FAIL dir%0d_busy got=gap%0d/after%b want=gap0/after0", i, bg, ab); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, m, res, exp_r;
      logic         sub, ad, ab;
      bit           bg;
      int           l, n, dd, ds;
      for (int i = 0; i < 16; i++) begin
         if (i == 0) m = '1;
         else begin
            m = rand_wide() >> $urandom_range(0, W - 3);
            m[0] = 1'b1;
            if (m < W'(3)) m = W'(3);
         end
         a = rand_wide() % m;
         b = rand_wide() % m;
         sub = 1'($urandom());
         l = $urandom_range(1, 6);
         exp_r = ref_mod(a, b, m, sub);
         run_op(a, b, m, sub, l, 0, 1'b0, res, n, dd, ds, ad, ab, bg);
         checks++; if (res !== exp_r) begin failures++; $display("FAIL rand%0d_result got=%h want=%h", i, res[31:0], exp_r[31:0]); end
         checks++; if (n !== 2 * l + 4) begin failures++; $display("FAIL rand%0d_latency got=%0d want=%0d", i, n, 2 * l + 4); end
         checks++; if (ds !== 2 || dd !== 1) begin failures++; $display("FAIL rand%0d_counts got=starts%0d/dones%0d want=2/1", i, ds, dd); end
      end
   endtask

   task automatic test_start_ignored();
      logic [W-1:0] res;
      logic         ad, ab;
      bit           bg;
      int           n, dd, ds;
      run_op(W'(7), W'(9), W'(13), 1'b0, 5, 3, 1'b0, res, n, dd, ds, ad, ab, bg);
      checks++; if (res !== W'(3)) begin failures++; $display("FAIL ign_result got=%h want=3", res[31:0]); end
      checks++; if (n !== 14) begin failures++; $display("FAIL ign_latency got=%0d want=14", n); end
      checks++; if (ds !== 2 || dd !== 1 || ad !== 1'b0) begin failures++; $display("FAIL ign_counts got=starts%0d/dones%0d/after%b want=2/1/0", ds, dd, ad); end
      repeat (12) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_no_second_op got=busy%b want=0", busy); end
   endtask

   task automatic test_abort();
      logic [W-1:0] res;
      logic         ad, ab;
      bit           bg;
      int           n, dd, ds, s0, d0, k;
      lat = 4;
      @(posedge clk);
      #1;
      s0 = starts_seen;
      in_a = W'(3); in_b = W'(8); in_m = W'(13); subtract = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      k = 0;
      while (starts_seen != s0 + 2 && k < TMO) begin
         @(posedge clk);
         #1;
         k++;
      end
      checks++; if (k >= TMO) begin failures++; $display("FAIL abort_reach_wait2 got=timeout want=second add_start"); end
      d0 = dones_seen;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      checks++; if (done !== 1'b0 || busy !== 1'b0 || add_start !== 1'b0) begin failures++; $display("FAIL abort_outputs got=done%b/busy%b/start%b want=0/0/0", done, busy, add_start); end
      repeat (8) @(posedge clk);
      #1;
      checks++; if (dones_seen !== d0 || busy !== 1'b0 || result !== '0) begin failures++; $display("FAIL abort_late_add_done got=dones+%0d/busy%b/res%h want=0/0/0", dones_seen - d0, busy, result[31:0]); end
      run_op(W'(8), W'(3), W'(13), 1'b1, 2, 0, 1'b0, res, n, dd, ds, ad, ab, bg);
      checks++; if (res !== W'(5)) begin failures++; $display("FAIL abort_recover_result got=%h want=5", res[31:0]); end
      checks++; if (n !== 8 || ds !== 2 || dd !== 1) begin failures++; $display("FAIL abort_recover_timing got=lat%0d/starts%0d/dones%0d want=8/2/1", n, ds, dd); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] res;
      logic         ad, ab;
      bit           bg;
      int           n, dd, ds;
      run_op(W'(5), W'(6), W'(13), 1'b0, 2, 0, 1'b0, res, n, dd, ds, ad, ab, bg);
      checks++; if (res !== W'(11)) begin failures++; $display("FAIL b2b_first_result got=%h want=11", res[31:0]); end
      // run_op returns in the cycle after done, so this start is back-to-back.
      run_op(W'(12), W'(12), W'(13), 1'b0, 3, 0, 1'b1, res, n, dd, ds, ad, ab, bg);
      checks++; if (res !== W'(11)) begin failures++; $display("FAIL b2b_result got=%h want=11", res[31:0]); end
      checks++; if (n !== 10) begin failures++; $display("FAIL b2b_latency got=%0d want=10", n); end
      checks++; if (ds !== 2 || dd !== 1) begin failures++; $display("FAIL b2b_counts got=starts%0d/dones%0d want=2/1", ds, dd); end
      checks++; if (overlaps !== 0) begin failures++; $display("FAIL adder_overlap got=%0d want=0", overlaps); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
